// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer for a small accumulator-style datapath: fetches an
// instruction word, walks it through LOAD/EXEC/WB, and drives the datapath strobes.
module seq_control_unit #(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INSTR_W-1:0]         instruction,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic                       zero_flag_from_alu,
  input  logic                       bus_ready,
  output logic                       reg_a_enable,
  output logic                       reg_r_enable,
  output logic                       reg_file_master_enable,
  output logic [2**REG_ADDR_W-1:0]   reg_file_write_enable_mask,
  output logic [REG_ADDR_W-1:0]      reg_read_addr_x,
  output logic [REG_ADDR_W-1:0]      reg_read_addr_y,
  output logic [REG_ADDR_W-1:0]      reg_write_addr,
  output logic [2:0]                 alu_op_code,
  output logic                       mux_sel_op_a,
  output logic                       mux_sel_op_b,
  output logic                       bus_output_enable,
  output logic                       pc_write_enable,
  output logic                       pc_source_mux_select,
  output logic                       halted,
  output logic [CNT_W-1:0]           retired_count
);

  typedef enum logic [2:0] {S_FETCH, S_LOAD, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NAN = 3'b010, OP_HLT = 3'b011,
    OP_OUT = 3'b100, OP_LDI = 3'b101, OP_BNE = 3'b110, OP_REP = 3'b111
  } opcode_t;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_NAN    = 3'b010;
  localparam logic [2:0] ALU_PASS_A = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic                 branch_taken;
  logic [CNT_W-1:0]     count;
  opcode_t              op;
  logic                 no_writeback;
  logic                 unused_ir_bits;

  assign op              = opcode_t'(ir[INSTR_W-1 -: 3]);
  assign reg_read_addr_x = ir[INSTR_W-4 -: REG_ADDR_W];
  assign reg_read_addr_y = ir[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
  assign reg_write_addr  = reg_read_addr_x;
  assign no_writeback    = (op == OP_OUT) || (op == OP_BNE);
  assign unused_ir_bits  = ^ir;

  assign pc_source_mux_select = branch_taken;
  assign retired_count        = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_FETCH;
      ir           <= '0;
      branch_taken <= 1'b0;
      count        <= '0;
    end else begin
      if (pc_write_enable) count <= count + 1'b1;
      case (state)
        S_FETCH: if (instr_valid) begin
          ir           <= instruction;
          branch_taken <= 1'b0;
          state        <= S_LOAD;
        end
        S_LOAD:  state <= (op == OP_HLT) ? S_HALT : S_EXEC;
        S_EXEC: begin
          branch_taken <= (op == OP_BNE) && !zero_flag_from_alu;
          state        <= S_WB;
        end
        S_WB:    if (op != OP_OUT || bus_ready) state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Everything but the OUT handshake is decoded from state and IR; the OUT
  // write-back completes in the same cycle the consumer takes the data.
  always_comb begin
    instr_ready                = 1'b0;
    reg_a_enable               = 1'b0;
    reg_r_enable               = 1'b0;
    reg_file_master_enable     = 1'b0;
    reg_file_write_enable_mask = '0;
    alu_op_code                = ALU_ADD;
    mux_sel_op_a               = 1'b0;
    mux_sel_op_b               = 1'b0;
    bus_output_enable          = 1'b0;
    pc_write_enable            = 1'b0;
    halted                     = 1'b0;
    case (state)
      S_FETCH: instr_ready = 1'b1;
      S_LOAD: begin
        reg_a_enable = 1'b1;
        mux_sel_op_a = (op == OP_LDI);
      end
      S_EXEC: begin
        case (op)
          OP_ADD:  alu_op_code = ALU_ADD;
          OP_SUB:  alu_op_code = ALU_SUB;
          OP_NAN:  alu_op_code = ALU_NAN;
          OP_REP:  alu_op_code = ALU_PASS_B;
          default: alu_op_code = ALU_PASS_A;
        endcase
        reg_r_enable = !no_writeback;
        mux_sel_op_b = (op == OP_LDI);
      end
      S_WB: begin
        if (op == OP_OUT) begin
          bus_output_enable = 1'b1;
          pc_write_enable   = bus_ready;
        end else begin
          pc_write_enable = 1'b1;
          if (op != OP_BNE) begin
            reg_file_master_enable                      = 1'b1;
            reg_file_write_enable_mask[reg_write_addr]  = 1'b1;
          end
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: per-scenario tasks with hand-computed expectations.
module tb_seq_control_unit;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, NAN = 3'b010, HLT = 3'b011;
  localparam logic [2:0] OUT = 3'b100, LDI = 3'b101, BNE = 3'b110, REP = 3'b111;

  logic        clock = 1'b0;
  logic        reset, instr_valid, zero_flag_from_alu, bus_ready;
  logic [15:0] instruction;

  logic        instr_ready, reg_a_enable, reg_r_enable, reg_file_master_enable;
  logic [7:0]  reg_file_write_enable_mask;
  logic [2:0]  reg_read_addr_x, reg_read_addr_y, reg_write_addr, alu_op_code;
  logic        mux_sel_op_a, mux_sel_op_b, bus_output_enable, pc_write_enable;
  logic        pc_source_mux_select, halted;
  logic [15:0] retired_count;

  logic        s_instr_ready, s_reg_a_enable, s_reg_r_enable, s_reg_file_master_enable;
  logic [7:0]  s_mask;
  logic [2:0]  s_addr_x, s_addr_y, s_waddr, s_alu;
  logic        s_mux_a, s_mux_b, s_boe, s_pcwe, s_pcsrc, s_halted;
  logic [3:0]  s_retired;

  int vectors = 0;
  int miscompares = 0;
  int exp_ret = 0;

  always #5 clock = ~clock;

  seq_control_unit u_dut (
    .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero_flag_from_alu(zero_flag_from_alu), .bus_ready(bus_ready),
    .reg_a_enable(reg_a_enable), .reg_r_enable(reg_r_enable),
    .reg_file_master_enable(reg_file_master_enable),
    .reg_file_write_enable_mask(reg_file_write_enable_mask),
    .reg_read_addr_x(reg_read_addr_x), .reg_read_addr_y(reg_read_addr_y),
    .reg_write_addr(reg_write_addr), .alu_op_code(alu_op_code),
    .mux_sel_op_a(mux_sel_op_a), .mux_sel_op_b(mux_sel_op_b),
    .bus_output_enable(bus_output_enable), .pc_write_enable(pc_write_enable),
    .pc_source_mux_select(pc_source_mux_select), .halted(halted),
    .retired_count(retired_count)
  );

  seq_control_unit #(.CNT_W(4)) u_small (
    .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(s_instr_ready), .zero_flag_from_alu(zero_flag_from_alu), .bus_ready(bus_ready),
    .reg_a_enable(s_reg_a_enable), .reg_r_enable(s_reg_r_enable),
    .reg_file_master_enable(s_reg_file_master_enable),
    .reg_file_write_enable_mask(s_mask),
    .reg_read_addr_x(s_addr_x), .reg_read_addr_y(s_addr_y),
    .reg_write_addr(s_waddr), .alu_op_code(s_alu),
    .mux_sel_op_a(s_mux_a), .mux_sel_op_b(s_mux_b),
    .bus_output_enable(s_boe), .pc_write_enable(s_pcwe),
    .pc_source_mux_select(s_pcsrc), .halted(s_halted),
    .retired_count(s_retired)
  );

  // {a, r, master, mux_a, mux_b, bus_oe, pc_we, pc_src, halted, ready}
  logic [9:0] ctl;
  assign ctl = {reg_a_enable, reg_r_enable, reg_file_master_enable, mux_sel_op_a,
                mux_sel_op_b, bus_output_enable, pc_write_enable, pc_source_mux_select,
                halted, instr_ready};

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x,
                                      input logic [2:0] y);
    return {op, x, y, 7'b0};
  endfunction

  task automatic cyc;
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1; instr_valid = 1'b0; zero_flag_from_alu = 1'b0; bus_ready = 1'b1;
    instruction = 16'hFFFF;
    cyc; cyc;
    reset = 1'b0;
    #1;
    vectors++;
    if ({ctl, alu_op_code, reg_file_write_enable_mask, reg_read_addr_x} !== {10'b0000000001, 3'b0, 8'b0, 3'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: ctl=%b alu=%b mask=%b x=%0d required ctl=0000000001 alu=0 mask=0 x=0",
               ctl, alu_op_code, reg_file_write_enable_mask, reg_read_addr_x);
    end
    vectors++;
    if (retired_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d required 0", retired_count);
    end
    exp_ret = 0;
  endtask

  task automatic test_add;
    instruction = enc(ADD, 3'd2, 3'd3); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    vectors++;
    if ({ctl, reg_read_addr_x, reg_read_addr_y} !== {10'b1000000000, 3'd2, 3'd3}) begin
      miscompares++;
      $display("FAIL add_load: ctl=%b x=%0d y=%0d required ctl=1000000000 x=2 y=3",
               ctl, reg_read_addr_x, reg_read_addr_y);
    end
    cyc;
    vectors++;
    if ({ctl, alu_op_code} !== {10'b0100000000, 3'b000}) begin
      miscompares++;
      $display("FAIL add_exec: ctl=%b alu=%b required ctl=0100000000 alu=000", ctl, alu_op_code);
    end
    cyc;
    vectors++;
    if ({ctl, reg_file_write_enable_mask, reg_write_addr, alu_op_code} !==
        {10'b0010001000, 8'b00000100, 3'd2, 3'b000}) begin
      miscompares++;
      $display("FAIL add_wb: ctl=%b mask=%b waddr=%0d alu=%b required ctl=0010001000 mask=00000100 waddr=2 alu=000",
               ctl, reg_file_write_enable_mask, reg_write_addr, alu_op_code);
    end
    cyc; exp_ret++;
    vectors++;
    if ({ctl, retired_count} !== {10'b0000000001, 16'(exp_ret)}) begin
      miscompares++;
      $display("FAIL add_retire: ctl=%b count=%0d required ctl=0000000001 count=%0d",
               ctl, retired_count, exp_ret);
    end
  endtask

  task automatic test_alu_ops;
    logic [2:0] ops [6]  = '{SUB, NAN, LDI, REP, BNE, OUT};
    logic [2:0] alus [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b011, 3'b011};
    zero_flag_from_alu = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic ldi, wr, outop;
      logic [2:0] x;
      logic [7:0] exp_mask;
      ldi = (ops[i] == LDI); outop = (ops[i] == OUT);
      wr = !(ops[i] == BNE || outop);
      x = 3'(i + 1);
      exp_mask = wr ? (8'b1 << x) : 8'b0;
      instruction = enc(ops[i], x, 3'd7 - x); instr_valid = 1'b1;
      cyc; instr_valid = 1'b0;
      vectors++;
      if ({ctl, alu_op_code} !== {1'b1, 2'b00, ldi, 6'b0, 3'b000}) begin
        miscompares++;
        $display("FAIL op%0d_load: ctl=%b alu=%b required mux_a=%b", ops[i], ctl, alu_op_code, ldi);
      end
      cyc;
      vectors++;
      if ({ctl, alu_op_code} !== {1'b0, wr, 2'b00, ldi, 5'b0, alus[i]}) begin
        miscompares++;
        $display("FAIL op%0d_exec: ctl=%b alu=%b required r_en=%b mux_b=%b alu=%b",
                 ops[i], ctl, alu_op_code, wr, ldi, alus[i]);
      end
      cyc;
      vectors++;
      if ({ctl, reg_file_write_enable_mask, alu_op_code} !==
          {2'b00, wr, 2'b00, outop, 4'b1000, exp_mask, 3'b000}) begin
        miscompares++;
        $display("FAIL op%0d_wb: ctl=%b mask=%b alu=%b required master=%b bus_oe=%b mask=%b",
                 ops[i], ctl, reg_file_write_enable_mask, alu_op_code, wr, outop, exp_mask);
      end
      cyc; exp_ret++;
    end
    vectors++;
    if (retired_count !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL alu_ops_count: got %0d required %0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_bne;
    zero_flag_from_alu = 1'b0;
    instruction = enc(BNE, 3'd4, 3'd5); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    cyc; cyc;
    vectors++;
    if ({ctl, reg_file_write_enable_mask} !== {10'b0000001100, 8'b0}) begin
      miscompares++;
      $display("FAIL bne_taken_wb: ctl=%b mask=%b required ctl=0000001100 mask=0", ctl, reg_file_write_enable_mask);
    end
    cyc; exp_ret++;
    vectors++;
    if (ctl !== 10'b0000000101) begin
      miscompares++;
      $display("FAIL bne_taken_fetch: ctl=%b required 0000000101", ctl);
    end
    instruction = enc(ADD, 3'd1, 3'd1); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    vectors++;
    if (ctl !== 10'b1000000000) begin
      miscompares++;
      $display("FAIL bne_clear_on_load: ctl=%b required 1000000000", ctl);
    end
    cyc; cyc; cyc; exp_ret++;
    zero_flag_from_alu = 1'b1;
    instruction = enc(BNE, 3'd4, 3'd5); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    cyc; cyc;
    vectors++;
    if ({ctl, reg_file_write_enable_mask} !== {10'b0000001000, 8'b0}) begin
      miscompares++;
      $display("FAIL bne_not_taken_wb: ctl=%b mask=%b required ctl=0000001000 mask=0", ctl, reg_file_write_enable_mask);
    end
    cyc; exp_ret++;
  endtask

  task automatic test_out_stall;
    int ncyc, wb, boe, pcw;
    bus_ready = 1'b0; wb = 0; boe = 0; pcw = 0;
    instruction = enc(OUT, 3'd1, 3'd0); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0; ncyc = 1;
    while (!instr_ready && ncyc < 20) begin
      if (bus_output_enable) begin
        wb++;
        if (wb == 4) bus_ready = 1'b1;
      end
      #1;
      if (bus_output_enable) boe++;
      if (pc_write_enable) pcw++;
      cyc; ncyc++;
    end
    exp_ret++;
    bus_ready = 1'b1;
    vectors++;
    if ({ncyc, boe, pcw} !== {32'd7, 32'd4, 32'd1}) begin
      miscompares++;
      $display("FAIL out_stall: cycles=%0d bus_oe=%0d pc_we=%0d required cycles=7 bus_oe=4 pc_we=1", ncyc, boe, pcw);
    end
    vectors++;
    if (retired_count !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL out_count: got %0d required %0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_halt;
    int bad;
    bad = 0;
    instruction = enc(HLT, 3'd0, 3'd0); instr_valid = 1'b1;
    cyc;
    vectors++;
    if (ctl !== 10'b1000000000) begin
      miscompares++;
      $display("FAIL halt_load: ctl=%b required 1000000000", ctl);
    end
    cyc;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({ctl, alu_op_code, reg_file_write_enable_mask, retired_count} !==
          {10'b0000000010, 3'b0, 8'b0, 16'(exp_ret)}) begin
        miscompares++;
        $display("FAIL halt_hold: cycle %0d ctl=%b count=%0d required ctl=0000000010 count=%0d",
                 i, ctl, retired_count, exp_ret);
      end
      cyc;
    end
    instr_valid = 1'b0; reset = 1'b1;
    cyc; reset = 1'b0; exp_ret = 0;
    vectors++;
    if ({ctl, retired_count} !== {10'b0000000001, 16'd0}) begin
      miscompares++;
      $display("FAIL halt_reset: ctl=%b count=%0d required ctl=0000000001 count=0", ctl, retired_count);
    end
  endtask

  task automatic test_idle;
    instruction = enc(ADD, 3'd5, 3'd6); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    cyc; cyc; cyc; exp_ret++;
    instruction = enc(NAN, 3'd1, 3'd1);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({ctl, reg_read_addr_x, reg_read_addr_y, reg_write_addr} !== {10'b0000000001, 3'd5, 3'd6, 3'd5}) begin
        miscompares++;
        $display("FAIL idle_fetch: cycle %0d ctl=%b x=%0d y=%0d required ctl=0000000001 x=5 y=6",
                 i, ctl, reg_read_addr_x, reg_read_addr_y);
      end
      cyc;
    end
  endtask

  task automatic test_reset_mid;
    instruction = enc(ADD, 3'd1, 3'd2); instr_valid = 1'b1;
    cyc; instr_valid = 1'b0;
    cyc; reset = 1'b1;
    cyc; reset = 1'b0; exp_ret = 0;
    vectors++;
    if ({ctl, retired_count, reg_read_addr_x, reg_file_write_enable_mask} !==
        {10'b0000000001, 16'd0, 3'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: ctl=%b count=%0d x=%0d mask=%b required ctl=0000000001 count=0 x=0 mask=0",
               ctl, retired_count, reg_read_addr_x, reg_file_write_enable_mask);
    end
    cyc; cyc;
    vectors++;
    if ({ctl, retired_count} !== {10'b0000000001, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_after: ctl=%b count=%0d required ctl=0000000001 count=0", ctl, retired_count);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    reset = 1'b1; cyc; reset = 1'b0;
    instruction = enc(ADD, 3'd3, 3'd4); instr_valid = 1'b1;
    for (int i = 0; i < 68; i++) begin
      if (pc_write_enable) pulses++;
      cyc;
    end
    instr_valid = 1'b0;
    vectors++;
    if ({retired_count, pulses} !== {16'd17, 32'd17}) begin
      miscompares++;
      $display("FAIL b2b_count: count=%0d pulses=%0d required 17 and 17", retired_count, pulses);
    end
    vectors++;
    if (s_retired !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_cnt4: got %0d required 1", s_retired);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add;
    test_alu_ops;
    test_bne;
    test_out_stall;
    test_halt;
    test_idle;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
